// File: rtl/alu_result_select_if.sv
// Issue/write-back bundle between the ALU result channels and the registered result selector.
// The master drives the operation and channel results; the slave returns the selected result and status pulses.
interface alu_result_select_if #(
    parameter int WIDTH  = 24,
    parameter int NUM_IN = 6,
    parameter int SEL_W  = 3
);
    logic                    start;
    logic [SEL_W-1:0]        selector;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_done;
    logic                    ready;
    logic [WIDTH-1:0]        result;
    logic                    result_valid;
    logic                    zero_flag;
    logic                    illegal_sel;
    logic                    timeout;

    modport master (
        output start, selector, in_data, in_done,
        input  ready, result, result_valid, zero_flag, illegal_sel, timeout
    );

    modport slave (
        input  start, selector, in_data, in_done,
        output ready, result, result_valid, zero_flag, illegal_sel, timeout
    );
endinterface

// File: rtl/alu_result_select.sv
// Registered ALU result selector: one-hot channel mux, multi-cycle done handshake with a watchdog,
// and a held write-back result with zero flag and single-cycle status pulses.

// One result channel: contributes its data, done and multi-cycle flag only when selected.
module alu_rs_lane #(
    parameter int   WIDTH = 24,
    parameter int   SEL_W = 3,
    parameter int   IDX   = 0,
    parameter logic MC    = 1'b0
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] data,
    input  logic             done,
    output logic [WIDTH-1:0] hit_data,
    output logic             hit_done,
    output logic             hit_mc
);
    logic hit;

    assign hit      = (sel == SEL_W'(IDX));
    assign hit_data = hit ? data : '0;
    // Done is only meaningful for multi-cycle channels.
    assign hit_done = hit & done & MC;
    assign hit_mc   = hit & MC;
endmodule

module alu_result_select #(
    parameter int                WIDTH   = 24,
    parameter int                NUM_IN  = 6,
    parameter int                SEL_W   = 3,
    parameter logic [NUM_IN-1:0] MC_MASK = 6'b010000,
    parameter int                TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_select_if.slave  bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [SEL_W:0]   NUM_IN_X = (SEL_W + 1)'(NUM_IN);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             valid;
        logic             illegal;
        logic             tmo;
    } rsp_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] cap_q, cap_d;
    rsp_t             rsp_q, rsp_d;
    logic             zero_q, zero_d;

    logic [SEL_W-1:0]              mux_sel;
    logic [NUM_IN-1:0][WIDTH-1:0]  ch_data;
    logic [NUM_IN-1:0][WIDTH-1:0]  lane_data;
    logic [NUM_IN-1:0]             lane_done;
    logic [NUM_IN-1:0]             lane_mc;
    logic [WIDTH-1:0]              sel_data;
    logic                          sel_done;
    logic                          sel_mc;
    logic                          illegal;

    // While waiting, the captured selector owns the mux so live selector changes are harmless.
    assign mux_sel = (state_q == S_WAIT) ? cap_q : bus.selector;
    assign ch_data = bus.in_data;
    assign illegal = ({1'b0, bus.selector} >= NUM_IN_X);

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        alu_rs_lane #(
            .WIDTH (WIDTH),
            .SEL_W (SEL_W),
            .IDX   (i),
            .MC    (MC_MASK[i])
        ) u_lane (
            .sel      (mux_sel),
            .data     (ch_data[i]),
            .done     (bus.in_done[i]),
            .hit_data (lane_data[i]),
            .hit_done (lane_done[i]),
            .hit_mc   (lane_mc[i])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) sel_data |= lane_data[i];
    end

    assign sel_done = |lane_done;
    assign sel_mc   = |lane_mc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        rsp_d       = rsp_q;
        rsp_d.valid   = 1'b0;
        rsp_d.illegal = 1'b0;
        rsp_d.tmo     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (illegal) begin
                        rsp_d.illegal = 1'b1;
                    end else if (sel_mc) begin
                        cap_d   = bus.selector;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        rsp_d.data  = sel_data;
                        rsp_d.valid = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Done on the last allowed cycle wins over the watchdog.
                if (sel_done) begin
                    rsp_d.data  = sel_data;
                    rsp_d.valid = 1'b1;
                    state_d     = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_d.data = '0;
                    rsp_d.tmo  = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        zero_d = (rsp_d.data == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            rsp_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            rsp_q   <= rsp_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.ready        = (state_q == S_IDLE);
    assign bus.result       = rsp_q.data;
    assign bus.result_valid = rsp_q.valid;
    assign bus.illegal_sel  = rsp_q.illegal;
    assign bus.timeout      = rsp_q.tmo;
    assign bus.zero_flag    = zero_q;
endmodule

// File: tb/tb_alu_result_select.sv
// Randomized scoreboard bench for alu_result_select: the driver pushes the expected pulse per
// operation, an independent monitor pops on every pulse and checks the held result in between.
module tb_alu_result_select;
    localparam int                WIDTH   = 24;
    localparam int                NUM_IN  = 6;
    localparam int                SEL_W   = 3;
    localparam int                TIMEOUT = 32;
    localparam logic [NUM_IN-1:0] MC_MASK = 6'b010000;

    localparam logic [2:0] K_RV  = 3'b001;
    localparam logic [2:0] K_ILL = 3'b010;
    localparam logic [2:0] K_TO  = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_result_select_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

    alu_result_select #(
        .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .MC_MASK(MC_MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]       kind;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] hold_res = '0;
    logic [WIDTH-1:0] model_last = '0;
    logic [NUM_IN-1:0][WIDTH-1:0] chans;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [2:0] kind, input logic [WIDTH-1:0] res);
        exp_t e;
        e.kind = kind;
        e.res  = res;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_chans();
        for (int i = 0; i < NUM_IN; i++) chans[i] = WIDTH'($urandom);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("ready_before_issue", 32'(bus.ready), 32'd1);
    endtask

    // Operations on combinational channels or illegal selectors.
    task automatic single_op(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] data);
        wait_ready();
        rand_chans();
        if (int'(sel) < NUM_IN) chans[sel] = data;
        bus.in_data  = chans;
        bus.selector = sel;
        bus.in_done  = NUM_IN'($urandom);
        bus.start    = 1'b1;
        if (int'(sel) >= NUM_IN) begin
            push_exp(K_ILL, model_last);
        end else begin
            push_exp(K_RV, data);
            model_last = data;
        end
        tick();
        bus.start   = 1'b0;
        bus.in_done = '0;
        chk("ready_after_single", 32'(bus.ready), 32'd1);
    endtask

    // Multi-cycle op; done arrives in WAIT cycle k (k > TIMEOUT means never).
    task automatic mc_op(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] data,
                         input int k, input bit early_done);
        logic [NUM_IN-1:0] d;
        wait_ready();
        rand_chans();
        bus.in_data  = chans;
        bus.selector = sel;
        d            = '0;
        d[sel]       = early_done;
        bus.in_done  = d;
        bus.start    = 1'b1;
        tick();
        for (int c = 1; c <= TIMEOUT; c++) begin
            chk("ready_low_in_wait", 32'(bus.ready), 32'd0);
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.selector = SEL_W'($urandom);
            d            = NUM_IN'($urandom);
            d[sel]       = 1'b0;
            rand_chans();
            if (c == k) begin
                chans[sel] = data;
                d[sel]     = 1'b1;
                push_exp(K_RV, data);
                model_last = data;
            end else if (c == TIMEOUT) begin
                push_exp(K_TO, '0);
                model_last = '0;
            end
            bus.in_done = d;
            bus.in_data = chans;
            tick();
            if (c == k || c == TIMEOUT) break;
        end
        bus.start   = 1'b0;
        bus.in_done = '0;
        chk("ready_after_mc", 32'(bus.ready), 32'd1);
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            rand_chans();
            bus.in_data  = chans;
            bus.selector = SEL_W'($urandom);
            bus.in_done  = NUM_IN'($urandom);
            bus.start    = 1'b0;
            tick();
        end
        bus.in_done = '0;
    endtask

    // Monitor: every pulse must match the next expectation; otherwise the result must hold.
    initial begin
        logic [2:0] kind;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            kind = {bus.timeout, bus.illegal_sel, bus.result_valid};
            if (kind != 3'b000) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got kind %b expected none at %0t", kind, $time);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", 32'(kind), 32'(e.kind));
                    chk("pulse_result", 32'(bus.result), 32'(e.res));
                    chk("pulse_zero", 32'(bus.zero_flag), 32'(e.res == '0));
                    hold_res = e.res;
                end
            end else begin
                chk("hold_result", 32'(bus.result), 32'(hold_res));
                chk("hold_zero", 32'(bus.zero_flag), 32'(hold_res == '0));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
        int k;

        bus.start    = 1'b0;
        bus.selector = '0;
        bus.in_data  = '0;
        bus.in_done  = '0;
        rst          = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_ready", 32'(bus.ready), 32'd1);
        chk("reset_result", 32'(bus.result), 32'd0);
        chk("reset_zero", 32'(bus.zero_flag), 32'd1);
        chk("reset_pulses", 32'({bus.timeout, bus.illegal_sel, bus.result_valid}), 32'd0);

        single_op(3'd2, 24'h001234);
        single_op(3'd5, 24'h000000);
        idle_noise(4);
        mc_op(3'd4, 24'hABCDEF, 3, 1'b1);
        mc_op(3'd4, 24'h123456, TIMEOUT + 1, 1'b0);
        mc_op(3'd4, 24'h55AA55, TIMEOUT, 1'b0);
        single_op(3'd2, 24'h001234);
        single_op(3'd7, 24'hFFFFFF);
        single_op(3'd6, 24'h0F0F0F);

        // Reset abandons a pending multi-cycle op and beats a same-cycle Start/InDone.
        wait_ready();
        bus.selector = 3'd4;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.selector = 3'd2;
        bus.in_done  = NUM_IN'(1) << 4;
        tick();
        rst        = 1'b0;
        bus.start  = 1'b0;
        sb.delete();
        hold_res   = '0;
        model_last = '0;
        chk("rst_mid_wait_ready", 32'(bus.ready), 32'd1);
        chk("rst_mid_wait_result", 32'(bus.result), 32'd0);
        chans       = '0;
        chans[4]    = 24'h777777;
        bus.in_data = chans;
        bus.in_done = NUM_IN'(1) << 4;
        repeat (2) tick();
        bus.in_done = '0;

        for (int n = 0; n < 200; n++) begin
            sel  = SEL_W'($urandom_range(0, 7));
            data = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            if (int'(sel) < NUM_IN && MC_MASK[sel]) begin
                case ($urandom_range(0, 5))
                    0:       k = TIMEOUT + 1;
                    1:       k = TIMEOUT;
                    default: k = $urandom_range(1, 6);
                endcase
                mc_op(sel, data, k, 1'($urandom));
            end else begin
                single_op(sel, data);
            end
            if ($urandom_range(0, 4) == 0) idle_noise($urandom_range(1, 3));
        end

        idle_noise(5);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
